mem_port_arbiter: RTL and testbench

Single-port 64-bit memory with an arbiter that shares it between the instruction-fetch requester and the data (memory-stage) requester in the y86 core. Each access is serialized through a fixed-latency transaction FSM with a req/ack handshake. Data accesses have priority, and a starvation guard prevents fetch from being locked out. Read data, write commit and out-of-range error reporting are defined per transaction.

---
 rtl/y86_mem_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 26 ++
 rtl/mem_array.sv | 22 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/y86_mem_pkg.sv
// rtl/y86_mem_pkg.sv - shared types, defaults and memory-stage icodes for the y86 memory port
package y86_mem_pkg;

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {FETCH, DATA} owner_t;

   localparam int DEF_DEPTH  = 1024;
   localparam int DEF_LAT    = 2;
   localparam int DEF_STARVE = 4;

   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   // Memory stage drives d_we from this.
   function automatic logic icode_writes_mem(input logic [3:0] icode);
      return (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch and data requester bundle for the shared memory port
interface mem_port_arbiter_if #(parameter int AW = 64);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ack;
   logic [63:0]   i_rdata;
   logic          i_err;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [63:0]   d_wdata;
   logic          d_ack;
   logic [63:0]   d_rdata;
   logic          d_err;
   logic          busy;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, busy
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, busy
   );
endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port DEPTH x 64 array with one write enable and registered read
module mem_array #(
   parameter int DEPTH = 1024,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [IW-1:0] i_addr,
   input  logic [63:0]   i_wdata,
   output logic [63:0]   o_rdata
);
   logic [63:0] r_mem [DEPTH];
   logic [63:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) r_q <= r_mem[i_addr];
   end

   assign o_rdata = r_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serializes fetch and data accesses onto one array with data priority
// and a starvation guard; fixed LAT cycles from grant to ack.
module mem_port_arbiter
   import y86_mem_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AW     = 64,
   parameter int LAT    = DEF_LAT,
   parameter int STARVE = DEF_STARVE
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE + 1);

   state_t        r_state;
   owner_t        r_owner;
   logic [3:0]    r_cnt;
   logic [SW-1:0] r_starve;
   logic          r_we;
   logic          r_err;
   logic [63:0]   r_i_rdata;
   logic [63:0]   r_d_rdata;
   logic          r_i_err;
   logic          r_d_err;

   logic          w_grant;
   logic          w_pick_fetch;
   logic [AW-1:0] w_addr;
   logic          w_we;
   logic          w_oor;
   logic          w_done;
   logic          w_i_ack;
   logic          w_d_ack;
   logic [63:0]   w_q;
   logic [63:0]   w_rd;

   assign w_grant      = (r_state == IDLE) && (bus.i_req || bus.d_req);
   assign w_pick_fetch = bus.i_req && (!bus.d_req || (r_starve == SW'(STARVE)));
   assign w_addr       = w_pick_fetch ? bus.i_addr : bus.d_addr;
   assign w_we         = !w_pick_fetch && bus.d_we;
   assign w_oor        = (w_addr >= AW'(DEPTH));

   // The array is touched only on the grant edge; its read register then holds until the ack.
   mem_array #(.DEPTH(DEPTH), .IW(IW)) u_mem (
      .clk     (clk),
      .i_we    (w_grant && w_we && !w_oor),
      .i_re    (w_grant && !w_we && !w_oor),
      .i_addr  (w_addr[IW-1:0]),
      .i_wdata (bus.d_wdata),
      .o_rdata (w_q)
   );

   assign w_done  = (r_state == BUSY) && (r_cnt == '0);
   assign w_i_ack = w_done && (r_owner == FETCH);
   assign w_d_ack = w_done && (r_owner == DATA);
   assign w_rd    = r_err ? 64'd0 : (r_we ? r_d_rdata : w_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_owner   <= FETCH;
         r_cnt     <= '0;
         r_starve  <= '0;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_i_err   <= 1'b0;
         r_d_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_state <= BUSY;
                  r_owner <= w_pick_fetch ? FETCH : DATA;
                  r_cnt   <= 4'(LAT - 1);
                  r_we    <= w_we;
                  r_err   <= w_oor;
                  if (w_pick_fetch || !bus.i_req) r_starve <= '0;
                  else if (r_starve != SW'(STARVE)) r_starve <= r_starve + 1'b1;
               end
            end
            BUSY: begin
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               else r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         if (w_i_ack) begin
            r_i_rdata <= w_rd;
            r_i_err   <= r_err;
         end
         if (w_d_ack) begin
            r_d_rdata <= w_rd;
            r_d_err   <= r_err;
         end
      end
   end

   assign bus.i_ack   = w_i_ack;
   assign bus.d_ack   = w_d_ack;
   assign bus.i_rdata = w_i_ack ? w_rd : r_i_rdata;
   assign bus.d_rdata = w_d_ack ? w_rd : r_d_rdata;
   assign bus.i_err   = w_i_ack ? r_err : r_i_err;
   assign bus.d_err   = w_d_ack ? r_err : r_d_err;
   assign bus.busy    = (r_state == BUSY);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven and directed-sequence bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import y86_mem_pkg::*;

   logic clk = 1'b0;
   logic rst, rst3, rst1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(64)) bus  ();
   mem_port_arbiter_if #(.AW(64)) bus3 ();
   mem_port_arbiter_if #(.AW(64)) bus1 ();

   mem_port_arbiter #(.DEPTH(1024), .AW(64), .LAT(2), .STARVE(4)) dut  (.clk(clk), .rst(rst),  .bus(bus));
   mem_port_arbiter #(.DEPTH(1024), .AW(64), .LAT(3), .STARVE(4)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));
   mem_port_arbiter #(.DEPTH(1024), .AW(64), .LAT(1), .STARVE(4)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

   typedef struct {
      logic        fetch;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        chk_rd;
      logic [63:0] exp_rd;
      logic        exp_err;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   logic both_seen = 1'b0;

   always @(negedge clk) if (bus.i_ack && bus.d_ack) both_seen <= 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic main_wait(output int cyc, output logic gi, output logic gd);
      cyc = 0; gi = 1'b0; gd = 1'b0;
      while (!gi && !gd && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         gi = bus.i_ack;
         gd = bus.d_ack;
      end
   endtask

   task automatic clear_main();
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
   endtask

   vec_t vecs[14];

   initial begin
      int cyc;
      logic gi, gd;
      logic [63:0] r9v;
      logic got;
      logic [3:0] ack_pat;

      rst = 1'b1; rst3 = 1'b1; rst1 = 1'b1;
      clear_main();
      bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
      bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;
      bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;

      //            fetch we    addr           wdata                  chk   exp_rd                 err
      vecs[0]  = '{1'b0, 1'b1, 64'd5,    64'hDEADBEEF00000001, 1'b0, 64'h0,                 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 64'd5,    64'h0,                1'b1, 64'hDEADBEEF00000001, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 64'd0,    64'h0123456789ABCDEF, 1'b0, 64'h0,                 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 64'd3,    64'h3333000000000003, 1'b0, 64'h0,                 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 64'd7,    64'h7777000000000007, 1'b0, 64'h0,                 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 64'd0,    64'h0,                1'b1, 64'h0123456789ABCDEF, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 64'd5,    64'h0,                1'b1, 64'hDEADBEEF00000001, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 64'd1024, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0,                 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 64'd0,    64'h0,                1'b1, 64'h0123456789ABCDEF, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 64'd2000, 64'h0,                1'b1, 64'h0,                 1'b1};
      vecs[10] = '{1'b0, 1'b1, 64'd1023, 64'hA5A5A5A5A5A5A5A5, 1'b0, 64'h0,                 1'b0};
      vecs[11] = '{1'b1, 1'b0, 64'd1023, 64'h0,                1'b1, 64'hA5A5A5A5A5A5A5A5, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0,    1'b1, 64'h0,                 1'b1};
      vecs[13] = '{1'b1, 1'b0, 64'd7,    64'h0,                1'b1, 64'h7777000000000007, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; rst3 = 1'b0; rst1 = 1'b0;
      @(negedge clk);

      chk("rst_i_ack",   64'(bus.i_ack), 64'd0);
      chk("rst_d_ack",   64'(bus.d_ack), 64'd0);
      chk("rst_i_err",   64'(bus.i_err), 64'd0);
      chk("rst_d_err",   64'(bus.d_err), 64'd0);
      chk("rst_busy",    64'(bus.busy),  64'd0);
      chk("rst_i_rdata", bus.i_rdata,    64'd0);
      chk("rst_d_rdata", bus.d_rdata,    64'd0);

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].fetch) begin
            bus.i_req = 1'b1; bus.i_addr = vecs[i].addr;
         end else begin
            bus.d_req = 1'b1; bus.d_we = vecs[i].we; bus.d_addr = vecs[i].addr; bus.d_wdata = vecs[i].wdata;
         end
         main_wait(cyc, gi, gd);
         chk($sformatf("v%0d_ack_port", i), 64'({gi, gd}), vecs[i].fetch ? 64'd2 : 64'd1);
         chk($sformatf("v%0d_latency", i), 64'(cyc), 64'd2);
         chk($sformatf("v%0d_busy", i), 64'(bus.busy), 64'd1);
         if (vecs[i].chk_rd)
            chk($sformatf("v%0d_rdata", i), vecs[i].fetch ? bus.i_rdata : bus.d_rdata, vecs[i].exp_rd);
         chk($sformatf("v%0d_err", i), 64'(vecs[i].fetch ? bus.i_err : bus.d_err), 64'(vecs[i].exp_err));
         clear_main();
         @(posedge clk);
         @(negedge clk);
      end
      chk("idle_busy", 64'(bus.busy), 64'd0);

      // Simultaneous requests: data first, fetch at the first IDLE edge after d_ack.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd3;
      bus.i_req = 1'b1; bus.i_addr = 64'd7;
      main_wait(cyc, gi, gd);
      chk("sim_first_d", 64'({gi, gd}), 64'd1);
      chk("sim_d_rdata", bus.d_rdata, 64'h3333000000000003);
      bus.d_req = 1'b0;
      main_wait(cyc, gi, gd);
      chk("sim_second_i", 64'({gi, gd}), 64'd2);
      chk("sim_i_gap", 64'(cyc), 64'd3);
      chk("sim_i_rdata", bus.i_rdata, 64'h7777000000000007);
      chk("sim_d_rdata_hold", bus.d_rdata, 64'h3333000000000003);
      clear_main();
      @(posedge clk);
      @(negedge clk);

      // Starvation guard: both held, expect D,D,D,D,F twice.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd5;
      bus.i_req = 1'b1; bus.i_addr = 64'd0;
      for (int k = 0; k < 10; k++) begin
         main_wait(cyc, gi, gd);
         chk($sformatf("starve_g%0d", k), 64'({gi, gd}), ((k % 5) == 4) ? 64'd2 : 64'd1);
         if (k > 0) chk($sformatf("starve_gap%0d", k), 64'(cyc), 64'd3);
      end
      clear_main();
      @(posedge clk);
      @(negedge clk);
      chk("no_double_ack", 64'(both_seen), 64'd0);

      // Reset one cycle after a LAT=3 write grant.
      r9v = 64'h9999AAAA5555BEEF;
      bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_addr = 64'd9; bus3.d_wdata = r9v;
      @(posedge clk);
      @(negedge clk);
      chk("rmid_busy_before", 64'(bus3.busy), 64'd1);
      rst3 = 1'b1; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
      @(posedge clk); #1;
      chk("rmid_busy",    64'(bus3.busy),  64'd0);
      chk("rmid_d_ack",   64'(bus3.d_ack), 64'd0);
      chk("rmid_d_err",   64'(bus3.d_err), 64'd0);
      chk("rmid_d_rdata", bus3.d_rdata,    64'd0);
      chk("rmid_i_ack",   64'(bus3.i_ack), 64'd0);
      @(negedge clk);
      rst3 = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (bus3.d_ack) got = 1'b1;
      end
      chk("rmid_no_ack", 64'(got), 64'd0);
      @(negedge clk);
      bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 64'd9;
      cyc = 0;
      while (!bus3.d_ack && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("rmid_read_latency", 64'(cyc), 64'd3);
      chk("rmid_read_data", bus3.d_rdata, r9v);
      chk("rmid_read_err", 64'(bus3.d_err), 64'd0);
      bus3.d_req = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // LAT=1: preload words 0..2, then back-to-back fetches with i_req held.
      for (int k = 0; k < 3; k++) begin
         bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 64'(k); bus1.d_wdata = 64'h10000000000000A0 + 64'(k);
         cyc = 0;
         while (!bus1.d_ack && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk($sformatf("lat1_wr%0d_latency", k), 64'(cyc), 64'd1);
         bus1.d_req = 1'b0; bus1.d_we = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      bus1.i_req = 1'b1; bus1.i_addr = 64'd0;
      ack_pat = '0;
      for (int k = 0; k < 3; k++) begin
         cyc = 0;
         do begin
            @(posedge clk); #1;
            cyc++;
         end while (!bus1.i_ack && cyc < 20);
         chk($sformatf("lat1_f%0d_gap", k), 64'(cyc), (k == 0) ? 64'd1 : 64'd2);
         chk($sformatf("lat1_f%0d_rdata", k), bus1.i_rdata, 64'h10000000000000A0 + 64'(k));
         bus1.i_addr = 64'(k + 1);
      end
      bus1.i_req = 1'b0;
      @(posedge clk); #1;
      chk("lat1_ack_drop", 64'(bus1.i_ack), 64'd0);
      chk("lat1_i_rdata_hold", bus1.i_rdata, 64'h10000000000000A2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
